// File: rtl/t_ctrl_stall_seq.sv
// Pipeline stall/flush sequencer for the tProc control core.
// Turns hazard, flush, back-pressure and halt requests into per-stage advance enables and NOP strobes.
module t_ctrl_stall_seq #(
    parameter int FLUSH_CYC = 2,
    parameter int TMO_CYC   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    input  logic             ext_wait_i,
    input  logic             flush_i,
    input  logic             bubble_id_i,
    input  logic             bubble_rd_i,
    output logic             pc_en_o,
    output logic             id_en_o,
    output logic             rd_en_o,
    output logic             x_en_o,
    output logic             id_nop_o,
    output logic             rd_nop_o,
    output logic             flush_o,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int              TMO_W      = $clog2(TMO_CYC);
    localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);

    state_t           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [TMO_W-1:0] consec_q, consec_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;
    logic             stall;

    // NOTE: non-blocking assignments only in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            consec_q    <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            consec_q    <= consec_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        consec_d    = consec_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;

        if (!en_i) begin
            state_d     = S_IDLE;
            flush_cnt_d = '0;
            consec_d    = '0;
            timeout_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    if (ext_wait_i) begin
                        state_d = S_RUN;
                    end else if (flush_i) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (!bubble_rd_i && !bubble_id_i && halt_req_i) begin
                        state_d = S_HALT;
                    end
                end
                S_FLUSH: begin
                    // Back-pressure freezes the flush window; a new jump restarts it.
                    if (ext_wait_i) begin
                        flush_cnt_d = flush_cnt_q;
                    end else if (flush_i) begin
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (flush_cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
                S_HALT: if (resume_i) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase

            if (stall) begin
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
                if (consec_q == TMO_LAST) timeout_d = 1'b1;
                else                      consec_d  = consec_q + 1'b1;
            end else begin
                consec_d = '0;
            end
        end
    end

    always_comb begin
        pc_en_o  = 1'b0;
        id_en_o  = 1'b0;
        rd_en_o  = 1'b0;
        x_en_o   = 1'b0;
        id_nop_o = 1'b0;
        rd_nop_o = 1'b0;
        flush_o  = 1'b0;
        halted_o = 1'b0;
        stall    = 1'b0;

        if (en_i) begin
            unique case (state_q)
                S_RUN: begin
                    if (ext_wait_i) begin
                        stall = 1'b1;
                    end else if (flush_i) begin
                        {pc_en_o, id_en_o, rd_en_o, x_en_o} = 4'b1111;
                        id_nop_o = 1'b1;
                    end else if (bubble_rd_i) begin
                        x_en_o   = 1'b1;
                        rd_nop_o = 1'b1;
                        stall    = 1'b1;
                    end else if (bubble_id_i) begin
                        rd_en_o  = 1'b1;
                        x_en_o   = 1'b1;
                        id_nop_o = 1'b1;
                        stall    = 1'b1;
                    end else if (!halt_req_i) begin
                        {pc_en_o, id_en_o, rd_en_o, x_en_o} = 4'b1111;
                    end
                end
                S_FLUSH: begin
                    flush_o = 1'b1;
                    if (ext_wait_i) begin
                        stall = 1'b1;
                    end else begin
                        {pc_en_o, id_en_o, rd_en_o, x_en_o} = 4'b1111;
                        id_nop_o = 1'b1;
                    end
                end
                S_HALT:  halted_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign timeout_o   = timeout_q;

endmodule
